gray_rx_checker: RTL and testbench
==================================

Name: gray_rx_checker

Overview:
- Downstream consumer of the free-running Gray-code counter (`gray_c`, CBITS wide).
- Synchronises the Gray bus into the local clk domain and converts it to binary.
- Checks each update for a legal single step (+0 or +1, modulo 2^CBITS), counts violations and flags counter wrap-around.
- Sits between the counter and any logic that consumes a binary count, such as timestamping or FIFO pointer comparison.

Parameters:
- CBITS, 16, width of the Gray input and the binary output.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- LOCK_LEN, 4, consecutive legal +1 steps required to leave FAULT; legal range 1..15.
- ERRW, 8, width of the saturating error counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- gray_in, input, CBITS, Gray-coded count from upstream.
- err_clr, input, 1, synchronous clear of err_cnt.
- bin_out, output, CBITS, registered binary count.
- bin_valid, output, 1, high while bin_out is meaningful (state TRACK or FAULT).
- in_lock, output, 1, high in state TRACK.
- step_err, output, 1, one-cycle pulse on an illegal step.
- wrap_pulse, output, 1, one-cycle pulse on a legal wrap from all-ones to 0.
- err_cnt, output, ERRW, saturating count of step errors.
- dir, output, 1, last legal non-zero step direction (1 = down); tied 0 without the macro.

Behaviour:
- Reset values:
  - All sync flops 0; bin_out 0; prev_bin 0.
  - err_cnt 0; step_err, wrap_pulse, bin_valid, in_lock, dir all 0.
  - State ACQ; fill counter 0; lock counter 0.
- Synchroniser: gray_in passes through SYNC_STAGES flops. gray2bin is combinational on the last stage, registered into bin_out.
- Latency: a gray_in value stable from cycle t appears on bin_out at edge t+SYNC_STAGES+1.
- Step classification uses delta = (new_bin - prev_bin) mod 2^CBITS:
  - HOLD: delta = 0.
  - STEP: delta = 1.
  - BAD: any other delta.
  - prev_bin updates every cycle in TRACK and FAULT.
- State ACQ:
  - Fill counter increments each cycle.
  - When it reaches SYNC_STAGES+1, capture the converted value into bin_out and prev_bin, then go to TRACK.
  - No step_err, wrap_pulse or err_cnt activity in ACQ.
- State TRACK:
  - HOLD or STEP: stay in TRACK.
  - BAD: assert step_err for 1 cycle, increment err_cnt (saturating at 2^ERRW-1), clear lock counter, go to FAULT.
  - bin_out always follows the converted value, including on BAD.
- State FAULT:
  - STEP: lock counter +1; when it reaches LOCK_LEN, go to TRACK and clear the lock counter.
  - HOLD: lock counter unchanged.
  - BAD: step_err pulse, err_cnt +1 (saturating), lock counter cleared to 0.
- Wrap: wrap_pulse asserts only in TRACK, when prev_bin is all ones and new_bin is 0. It coincides with bin_out becoming 0.
- err_clr: clears err_cnt next cycle. If err_clr and a BAD step occur in the same cycle, the result is err_cnt = 1.
- Reset mid-operation: asynchronous return to all reset values and state ACQ; refill follows.
- An upstream counter reset (jump to 0 from non-all-ones) is a BAD step; the block counts it as an error.
- Output timing: all outputs are registered and change only on clk edges, apart from the asynchronous reset.

Optional Feature:
- Macro: GRAY_RX_BIDIR_EN.
- With the macro:
  - delta = 2^CBITS-1 (down by one) is a legal step. It is counted like STEP for the FAULT lock counter.
  - dir updates on every legal non-zero step (0 = up, 1 = down).
  - wrap_pulse also fires on 0 to all-ones while in TRACK.
- Without the macro:
  - Down-steps are BAD.
  - dir is constant 0.

Decomposition:
- Package gray_rx_pkg holds:
  - state enum {ACQ, TRACK, FAULT}.
  - step-class enum {HOLD, STEP, BAD}.
  - Parameterised gray2bin function (xor-prefix).
- Sub-module gray_sync: SYNC_STAGES-deep flop chain, CBITS wide, async reset to 0. It is instantiated once.

Test Plan:
- Reset, then gray_in driven by a counter from 0: in_lock=1 at cycle SYNC_STAGES+2; bin_out tracks the binary count with latency 3; err_cnt=0 after 1000 cycles.
- CBITS=4, count through 15 to 0: wrap_pulse exactly one cycle, coincident with bin_out=0; no step_err.
- Force gray_in from gray(5) to gray(9): step_err one pulse, err_cnt=1, in_lock=0. After 4 clean +1 steps, in_lock=1. A HOLD inside those 4 steps does not reset progress.
- Inject 300 BAD steps with ERRW=8: err_cnt saturates at 255. Then err_clr together with one BAD step gives err_cnt=1.
- Assert rst for 1 cycle mid-count at bin 1234: all outputs 0 immediately; relock after the fill period; no step_err on reacquire.
- With GRAY_RX_BIDIR_EN, count 3, 2, 1, 0, 15: no errors, dir=1, one wrap_pulse. Without the macro, the first down-step gives step_err.

Source files
------------

// File: rtl/gray_rx_pkg.sv
// Shared types and helpers for the Gray-count receiver/checker.
// Holds the tracker state enum, the per-update step classification and
// a width-generic Gray-to-binary conversion (xor prefix from the MSB down).
package gray_rx_pkg;

  // Tracker states: waiting for the synchroniser to fill, tracking
  // cleanly, or recovering after an illegal step.
  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Classification of one update relative to the previous binary value.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    BAD  = 2'd2
  } step_t;

  // Widest count the conversion helper handles; callers zero-extend
  // into it and truncate the result back to their own width. Zero
  // upper bits leave the prefix xor of the real bits unchanged.
  localparam int GRAY_MAX_W = 64;

  // Gray to binary: each binary bit is the xor of all Gray bits at or
  // above it, built as a running xor from the MSB downwards.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_rx_checker_sync.sv
// Multi-flop synchroniser for the incoming Gray bus.
// Latency: STAGES clk edges from i_d to o_q; no backpressure (free-running).
// Gray coding guarantees at most one bit changes per upstream update,
// so a bit-wise synchroniser still yields a coherent (old or new) value.
module gray_sync
  import gray_rx_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the asynchronous Gray value through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_rx_checker.sv
// Gray-count receiver: synchronise, convert to binary, police single steps.
// Latency: gray_in -> bin_out is SYNC_STAGES+1 clk edges; no backpressure.
// Optional build macro GRAY_RX_BIDIR_EN accepts down-by-one steps and drives dir.
module gray_rx_checker
  import gray_rx_pkg::*;
#(
  parameter int CBITS       = 16,  // count width, 1..GRAY_MAX_W
  parameter int SYNC_STAGES = 2,   // synchroniser depth, 2..4
  parameter int LOCK_LEN    = 4,   // clean +1 steps needed to leave FAULT, 1..15
  parameter int ERRW        = 8    // saturating error counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CBITS-1:0] gray_in,
  input  logic             err_clr,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_valid,
  output logic             in_lock,
  output logic             step_err,
  output logic             wrap_pulse,
  output logic [ERRW-1:0]  err_cnt,
  output logic             dir
);

  // Fill counter tops out at SYNC_STAGES+1 (at most 5), so 3 bits suffice.
  localparam logic [2:0]       FILL_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [3:0]       LOCK_TGT  = 4'(LOCK_LEN);
  localparam logic [ERRW-1:0]  ERR_MAX   = '1;
  localparam logic [CBITS-1:0] ALL_ONES  = '1;
  localparam logic [CBITS-1:0] ONE       = CBITS'(1);

  // Synchronised Gray value and its binary conversion.
  logic [CBITS-1:0] w_sync;
  logic [CBITS-1:0] w_bin;
  logic [CBITS-1:0] w_delta;
  step_t            w_class;
  logic             w_wrap;
  logic [ERRW-1:0]  w_err_bad;
  logic [3:0]       w_lock_inc;

  // Tracker state and registered outputs.
  state_t           r_state;
  logic [2:0]       r_fill;
  logic [3:0]       r_lock;
  logic [CBITS-1:0] r_bin;
  logic [CBITS-1:0] r_prev;
  logic [ERRW-1:0]  r_err_cnt;
  logic             r_step_err;
  logic             r_wrap;
  logic             r_bin_valid;
  logic             r_in_lock;

  gray_sync #(
    .WIDTH  (CBITS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (gray_in),
    .o_q (w_sync)
  );

  assign w_bin      = CBITS'(gray2bin(GRAY_MAX_W'(w_sync)));
  assign w_delta    = w_bin - r_prev;
  assign w_lock_inc = r_lock + 4'd1;

`ifdef GRAY_RX_BIDIR_EN
  logic w_down;
  logic r_dir;

  // Classify the update; a down-by-one step is legal in this build.
  always_comb begin
    w_class = BAD;
    w_down  = 1'b0;
    if (w_delta == '0) begin
      w_class = HOLD;
    end else if (w_delta == ONE) begin
      w_class = STEP;
    end else if (w_delta == ALL_ONES) begin
      w_class = STEP;
      w_down  = 1'b1;
    end
  end

  // Wrap in either direction across the all-ones / zero boundary.
  assign w_wrap = ((r_prev == ALL_ONES) && (w_bin == '0)) ||
                  ((r_prev == '0) && (w_bin == ALL_ONES));

  // Remember the direction of the most recent legal, non-zero step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir <= 1'b0;
    end else if ((r_state != ACQ) && (w_class == STEP)) begin
      r_dir <= w_down;
    end
  end

  assign dir = r_dir;
`else
  // Classify the update; only hold and +1 are legal in this build.
  always_comb begin
    w_class = BAD;
    if (w_delta == '0) begin
      w_class = HOLD;
    end else if (w_delta == ONE) begin
      w_class = STEP;
    end
  end

  // Upward wrap only: all-ones followed by zero.
  assign w_wrap = (r_prev == ALL_ONES) && (w_bin == '0);

  assign dir = 1'b0;
`endif

  // Error count after a BAD step; a simultaneous clear restarts it at one.
  assign w_err_bad = err_clr                 ? ERRW'(1) :
                     (r_err_cnt == ERR_MAX)  ? ERR_MAX  :
                                               r_err_cnt + ERRW'(1);

  // Tracker FSM: acquire after the synchroniser fills, then police steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACQ;
      r_fill      <= '0;
      r_lock      <= '0;
      r_bin       <= '0;
      r_prev      <= '0;
      r_err_cnt   <= '0;
      r_step_err  <= 1'b0;
      r_wrap      <= 1'b0;
      r_bin_valid <= 1'b0;
      r_in_lock   <= 1'b0;
    end else begin
      // Pulses default low; the clear may be overridden by a BAD step below.
      r_step_err <= 1'b0;
      r_wrap     <= 1'b0;
      if (err_clr) begin
        r_err_cnt <= '0;
      end

      case (r_state)
        ACQ: begin
          // Wait until the flop chain holds only post-reset samples.
          if (r_fill == FILL_DONE) begin
            r_bin       <= w_bin;
            r_prev      <= w_bin;
            r_bin_valid <= 1'b1;
            r_in_lock   <= 1'b1;
            r_state     <= TRACK;
          end else begin
            r_fill <= r_fill + 3'd1;
          end
        end

        TRACK: begin
          // The binary output follows the input even across a bad step.
          r_bin  <= w_bin;
          r_prev <= w_bin;
          if (w_class == BAD) begin
            r_step_err <= 1'b1;
            r_err_cnt  <= w_err_bad;
            r_lock     <= '0;
            r_in_lock  <= 1'b0;
            r_state    <= FAULT;
          end else begin
            r_wrap <= w_wrap;
          end
        end

        FAULT: begin
          r_bin  <= w_bin;
          r_prev <= w_bin;
          if (w_class == BAD) begin
            // Any further illegal step restarts the relock run.
            r_step_err <= 1'b1;
            r_err_cnt  <= w_err_bad;
            r_lock     <= '0;
          end else if (w_class == STEP) begin
            if (w_lock_inc == LOCK_TGT) begin
              r_lock    <= '0;
              r_in_lock <= 1'b1;
              r_state   <= TRACK;
            end else begin
              r_lock <= w_lock_inc;
            end
          end
          // HOLD keeps relock progress unchanged.
        end

        default: begin
          r_state <= ACQ;
        end
      endcase
    end
  end

  assign bin_out    = r_bin;
  assign bin_valid  = r_bin_valid;
  assign in_lock    = r_in_lock;
  assign step_err   = r_step_err;
  assign wrap_pulse = r_wrap;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_gray_rx_checker.sv
// Directed bench for gray_rx_checker: a 16-bit instance for tracking,
// fault/relock, saturation and reset, and a 4-bit instance for wrap and
// direction behaviour (build with or without GRAY_RX_BIDIR_EN).
module tb_gray_rx_checker;

  logic        clk;
  // 16-bit instance
  logic        rst16;
  logic [15:0] g16;
  logic        clr16;
  logic [15:0] bo16;
  logic        vld16, lk16, se16, wr16, dir16;
  logic [7:0]  ec16;
  // 4-bit instance
  logic        rst4;
  logic [3:0]  g4;
  logic        clr4;
  logic [3:0]  bo4;
  logic        vld4, lk4, se4, wr4, dir4;
  logic [7:0]  ec4;

  int errors = 0;
  int checks = 0;

  gray_rx_checker #(.CBITS(16)) u_dut16 (
    .clk(clk), .rst(rst16), .gray_in(g16), .err_clr(clr16),
    .bin_out(bo16), .bin_valid(vld16), .in_lock(lk16), .step_err(se16),
    .wrap_pulse(wr16), .err_cnt(ec16), .dir(dir16)
  );

  gray_rx_checker #(.CBITS(4)) u_dut4 (
    .clk(clk), .rst(rst4), .gray_in(g4), .err_clr(clr4),
    .bin_out(bo4), .bin_valid(vld4), .in_lock(lk4), .step_err(se4),
    .wrap_pulse(wr4), .err_cnt(ec4), .dir(dir4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] gray16(input int b);
    return 16'(b ^ (b >> 1));
  endfunction

  function automatic logic [3:0] gray4(input int b);
    return 4'(b ^ (b >> 1));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int nse;
    int nwr;
    int first_se_bin;

    rst16 = 1'b1; g16 = '0; clr16 = 1'b0;
    rst4  = 1'b1; g4  = '0; clr4  = 1'b0;
    tick(2);

    // Reset values
    chk("rst_bin",   32'(bo16), 0);
    chk("rst_valid", 32'(vld16), 0);
    chk("rst_lock",  32'(lk16), 0);
    chk("rst_err",   32'(ec16), 0);
    chk("rst_step",  32'(se16), 0);
    chk("rst_wrap",  32'(wr16), 0);
    chk("rst_dir",   32'(dir16), 0);

    // Acquisition: lock on the fourth edge after release
    rst16 = 1'b0;
    tick(3);
    chk("acq_lock_3", 32'(lk16), 0);
    chk("acq_valid_3", 32'(vld16), 0);
    tick(1);
    chk("acq_lock_4", 32'(lk16), 1);
    chk("acq_valid_4", 32'(vld16), 1);
    chk("acq_bin", 32'(bo16), 0);

    // Up-count: bin_out lags the driven value by three edges
    nse = 0; nwr = 0;
    for (int i = 1; i <= 1236; i++) begin
      g16 = gray16(i);
      tick(1);
      chk("track_bin", 32'(bo16), (i >= 2) ? i - 2 : 0);
      if (se16) nse++;
      if (wr16) nwr++;
    end
    chk("track_bin_1234", 32'(bo16), 1234);
    chk("track_no_step_err", nse, 0);
    chk("track_no_wrap", nwr, 0);
    chk("track_err_cnt", 32'(ec16), 0);
    chk("track_lock", 32'(lk16), 1);
    chk("track_dir", 32'(dir16), 0);

    // Asynchronous reset mid-count, outputs drop without a clock edge
    rst16 = 1'b1;
    #1;
    chk("midrst_bin",   32'(bo16), 0);
    chk("midrst_lock",  32'(lk16), 0);
    chk("midrst_valid", 32'(vld16), 0);
    chk("midrst_err",   32'(ec16), 0);
    g16 = gray16(1237);
    tick(1);
    rst16 = 1'b0;
    nse = 0;
    for (int k = 1; k <= 10; k++) begin
      g16 = gray16(1237 + k);
      tick(1);
      if (se16) nse++;
      chk("relock_lock", 32'(lk16), (k >= 4) ? 1 : 0);
      if (k == 4) chk("relock_capture", 32'(bo16), 1239);
    end
    chk("relock_bin", 32'(bo16), 1245);
    chk("relock_no_step_err", nse, 0);

    // Fault: jump from 5 to 9, then relock over four +1 steps with a hold
    rst16 = 1'b1; g16 = gray16(5);
    tick(2);
    rst16 = 1'b0;
    tick(6);
    chk("f_pre_lock", 32'(lk16), 1);
    chk("f_pre_bin", 32'(bo16), 5);
    g16 = gray16(9);
    tick(2);
    chk("f_step_early", 32'(se16), 0);
    tick(1);
    chk("f_step_err", 32'(se16), 1);
    chk("f_err_cnt", 32'(ec16), 1);
    chk("f_lock", 32'(lk16), 0);
    chk("f_bin", 32'(bo16), 9);
    chk("f_valid", 32'(vld16), 1);
    g16 = gray16(10); tick(1);
    chk("f_step_pulse_end", 32'(se16), 0);
    g16 = gray16(11); tick(1);
    tick(1);
    g16 = gray16(12); tick(1);
    g16 = gray16(13); tick(1);
    tick(1);
    chk("f_lock_after3", 32'(lk16), 0);
    tick(1);
    chk("f_lock_after4", 32'(lk16), 1);
    chk("f_bin_13", 32'(bo16), 13);
    chk("f_err_still1", 32'(ec16), 1);

    // Saturation: 300 alternating bad values, then hold
    for (int i = 0; i < 300; i++) begin
      g16 = (i % 2 == 1) ? gray16(200) : gray16(100);
      tick(1);
    end
    tick(4);
    chk("sat_err_cnt", 32'(ec16), 255);
    chk("sat_step_idle", 32'(se16), 0);
    chk("sat_lock", 32'(lk16), 0);
    g16 = gray16(250);
    tick(2);
    clr16 = 1'b1;
    tick(1);
    clr16 = 1'b0;
    chk("clr_bad_err_cnt", 32'(ec16), 1);
    chk("clr_bad_step", 32'(se16), 1);
    tick(1);
    clr16 = 1'b1;
    tick(1);
    clr16 = 1'b0;
    chk("clr_only", 32'(ec16), 0);

    // 4-bit wrap: count up through 15 to 0
    tick(1);
    rst4 = 1'b0;
    tick(5);
    chk("w4_lock", 32'(lk4), 1);
    nse = 0; nwr = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i <= 22) g4 = gray4(i % 16);
      tick(1);
      if (se4) nse++;
      if (wr4) begin
        nwr++;
        chk("w4_wrap_bin0", 32'(bo4), 0);
      end
    end
    chk("w4_wrap_count", nwr, 1);
    chk("w4_no_step_err", nse, 0);
    chk("w4_bin_end", 32'(bo4), 6);

    // Down-count 3,2,1,0,15
    rst4 = 1'b1; g4 = gray4(3);
    tick(1);
    rst4 = 1'b0;
    tick(5);
    chk("d4_lock", 32'(lk4), 1);
    chk("d4_bin", 32'(bo4), 3);
    nse = 0; nwr = 0; first_se_bin = -1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 1) g4 = gray4(2);
      if (i == 2) g4 = gray4(1);
      if (i == 3) g4 = gray4(0);
      if (i == 4) g4 = gray4(15);
      tick(1);
      if (se4) begin
        nse++;
        if (first_se_bin < 0) first_se_bin = int'(bo4);
      end
      if (wr4) nwr++;
    end
    chk("d4_bin_end", 32'(bo4), 15);
`ifdef GRAY_RX_BIDIR_EN
    chk("d4_step_errs", nse, 0);
    chk("d4_wraps", nwr, 1);
    chk("d4_dir", 32'(dir4), 1);
    chk("d4_lock_end", 32'(lk4), 1);
`else
    chk("d4_step_errs", nse, 4);
    chk("d4_first_err_bin", first_se_bin, 2);
    chk("d4_wraps", nwr, 0);
    chk("d4_dir", 32'(dir4), 0);
    chk("d4_lock_end", 32'(lk4), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
